// File: rtl/fp_mult_status_gen.sv
// Purpose: status byte generator after the FP multiplier rounding stage, with sticky status and error counter.
// Latency: 2 cycles from in_valid to out_valid, full throughput, results in order.
// Backpressure: none; one result can be accepted every cycle.
module fp_mult_status_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] z,
    input  logic        inexact_in,
    input  logic        overflow_in,
    input  logic        underflow_in,
    input  logic        nan_in,
    input  logic        sticky_clr,
    output logic        out_valid,
    output logic [7:0]  status,
    output logic [7:0]  sticky_status,
    output logic [7:0]  err_cnt
);

    // Sign of the result never affects any flag; kept only for readability of the port.
    logic unused_sign;
    assign unused_sign = z[31];

    // Stage 1 state: classification of the rounded result plus the raw flags
    logic s1_vld_q, s1_vld_d;
    logic s1_exp_ones_q, s1_exp_ones_d;
    logic s1_mant_zero_q, s1_mant_zero_d;
    logic s1_mag_zero_q, s1_mag_zero_d;
    logic s1_inexact_q, s1_inexact_d;
    logic s1_overflow_q, s1_overflow_d;
    logic s1_underflow_q, s1_underflow_d;
    logic s1_nan_q, s1_nan_d;

    // Stage 2 state: prioritised status byte and the inconsistency indication
    logic       s2_vld_q, s2_vld_d;
    logic [7:0] s2_status_q, s2_status_d;
    logic       s2_incons_q, s2_incons_d;

    // Output state
    logic       out_valid_q, out_valid_d;
    logic [7:0] status_q, status_d;
    logic [7:0] sticky_q, sticky_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Stage 1: classify the result fields; data only loads on a valid input
    always_comb begin
        s1_vld_d       = in_valid;
        s1_exp_ones_d  = s1_exp_ones_q;
        s1_mant_zero_d = s1_mant_zero_q;
        s1_mag_zero_d  = s1_mag_zero_q;
        s1_inexact_d   = s1_inexact_q;
        s1_overflow_d  = s1_overflow_q;
        s1_underflow_d = s1_underflow_q;
        s1_nan_d       = s1_nan_q;
        if (in_valid) begin
            s1_exp_ones_d  = (z[30:23] == 8'hFF);
            s1_mant_zero_d = (z[22:0] == 23'd0);
            s1_mag_zero_d  = (z[30:0] == 31'd0);
            s1_inexact_d   = inexact_in;
            s1_overflow_d  = overflow_in;
            s1_underflow_d = underflow_in;
            s1_nan_d       = nan_in;
        end
    end

    // Stage 2: flag priority NaN > huge > inf/zero > tiny so forbidden pairs cannot appear
    always_comb begin
        logic nan_f, huge_f, inf_f, zero_f, tiny_f, inexact_f;
        nan_f     = s1_nan_q | (s1_exp_ones_q & ~s1_mant_zero_q);
        huge_f    = s1_overflow_q & ~nan_f;
        inf_f     = s1_exp_ones_q & s1_mant_zero_q & ~nan_f;
        zero_f    = s1_mag_zero_q & ~nan_f & ~huge_f;
        tiny_f    = s1_underflow_q & ~nan_f & ~huge_f & ~inf_f;
        inexact_f = (s1_inexact_q | huge_f) & ~nan_f;

        s2_vld_d    = s1_vld_q;
        s2_status_d = s2_status_q;
        s2_incons_d = s2_incons_q;
        if (s1_vld_q) begin
            s2_status_d = {2'b00, inexact_f, huge_f, tiny_f, nan_f, inf_f, zero_f};
            s2_incons_d = (s1_overflow_q & s1_underflow_q)
                        | (nan_f & (s1_overflow_q | s1_underflow_q | s1_inexact_q))
                        | (s1_overflow_q & s1_mag_zero_q)
                        | (s1_underflow_q & s1_exp_ones_q);
        end
    end

    // Output stage: emit status, accumulate sticky history and the saturating error count
    always_comb begin
        out_valid_d = s2_vld_q;
        status_d    = status_q;
        sticky_d    = sticky_q;
        err_cnt_d   = err_cnt_q;
        if (s2_vld_q) begin
            status_d = s2_status_q;
            if (sticky_clr) begin
                // Clear drops old history but keeps the result leaving this cycle
                sticky_d  = s2_status_q;
                err_cnt_d = s2_incons_q ? 8'd1 : 8'd0;
            end else begin
                sticky_d = sticky_q | s2_status_q;
                if (s2_incons_q && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end else if (sticky_clr) begin
            sticky_d  = 8'h00;
            err_cnt_d = 8'h00;
        end
    end

    // State registers with synchronous active-low reset; in-flight results are dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q       <= 1'b0;
            s1_exp_ones_q  <= 1'b0;
            s1_mant_zero_q <= 1'b0;
            s1_mag_zero_q  <= 1'b0;
            s1_inexact_q   <= 1'b0;
            s1_overflow_q  <= 1'b0;
            s1_underflow_q <= 1'b0;
            s1_nan_q       <= 1'b0;
            s2_vld_q       <= 1'b0;
            s2_status_q    <= 8'h00;
            s2_incons_q    <= 1'b0;
            out_valid_q    <= 1'b0;
            status_q       <= 8'h00;
            sticky_q       <= 8'h00;
            err_cnt_q      <= 8'h00;
        end else begin
            s1_vld_q       <= s1_vld_d;
            s1_exp_ones_q  <= s1_exp_ones_d;
            s1_mant_zero_q <= s1_mant_zero_d;
            s1_mag_zero_q  <= s1_mag_zero_d;
            s1_inexact_q   <= s1_inexact_d;
            s1_overflow_q  <= s1_overflow_d;
            s1_underflow_q <= s1_underflow_d;
            s1_nan_q       <= s1_nan_d;
            s2_vld_q       <= s2_vld_d;
            s2_status_q    <= s2_status_d;
            s2_incons_q    <= s2_incons_d;
            out_valid_q    <= out_valid_d;
            status_q       <= status_d;
            sticky_q       <= sticky_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign status        = status_q;
    assign sticky_status = sticky_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_fp_mult_status_gen.sv
// Purpose: scoreboard bench for fp_mult_status_gen with directed vectors and a random invariant sweep.
// Latency: expects out_valid two edges after each accepted input.
// Backpressure: none; the monitor pops one expected entry per out_valid cycle.
module tb_fp_mult_status_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] z;
    logic        inexact_in, overflow_in, underflow_in, nan_in;
    logic        sticky_clr;
    logic        out_valid;
    logic [7:0]  status, sticky_status, err_cnt;

    int tests = 0;
    int fails = 0;

    // Expected entries: {incons, status}
    logic [8:0] exp_q[$];

    // Model of sticky/err, driven from what the monitor sees
    logic [7:0] m_sticky = 8'h00;
    logic [7:0] m_err    = 8'h00;
    logic       clr_seen = 1'b0;
    logic       rst_seen = 1'b1;
    int         run      = 0;
    int         last_run = 0;

    always #5 clk = ~clk;

    fp_mult_status_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .z            (z),
        .inexact_in   (inexact_in),
        .overflow_in  (overflow_in),
        .underflow_in (underflow_in),
        .nan_in       (nan_in),
        .sticky_clr   (sticky_clr),
        .out_valid    (out_valid),
        .status       (status),
        .sticky_status(sticky_status),
        .err_cnt      (err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic forbidden(input logic [7:0] s);
        logic zr, inf, nn, tiny, huge, inx;
        {inx, huge, tiny, nn, inf, zr} = s[5:0];
        return (zr & inf) | (zr & nn) | (zr & huge) | (inf & tiny) | (nn & tiny)
             | (nn & huge) | (nn & inx) | (huge & tiny) | (s[7:6] != 2'b00);
    endfunction

    // Reference status for random stimulus, written from the flag priority rules
    function automatic logic [8:0] ref_fn(input logic [31:0] zz, input logic inx, input logic ovf,
                                          input logic unf, input logic nn);
        logic eo, mz, mag, nan_f, huge_f, inf_f, zero_f, tiny_f, inx_f, inc;
        eo     = (zz[30:23] == 8'hFF);
        mz     = (zz[22:0] == 23'd0);
        mag    = (zz[30:0] == 31'd0);
        nan_f  = nn | (eo & ~mz);
        huge_f = ovf & ~nan_f;
        inf_f  = eo & mz & ~nan_f;
        zero_f = mag & ~nan_f & ~huge_f;
        tiny_f = unf & ~nan_f & ~huge_f & ~inf_f;
        inx_f  = (inx | huge_f) & ~nan_f;
        inc    = (ovf & unf) | (nan_f & (ovf | unf | inx)) | (ovf & mag) | (unf & eo);
        return {inc, 2'b00, inx_f, huge_f, tiny_f, nan_f, inf_f, zero_f};
    endfunction

    // Capture control inputs at the active edge for the model
    always @(posedge clk) begin
        clr_seen = sticky_clr;
        rst_seen = !rst_n;
    end

    // Monitor: pop and compare on every out_valid, track sticky/err model
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_seen) begin
            m_sticky = 8'h00;
            m_err    = 8'h00;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("status", {24'd0, status}, {24'd0, e[7:0]});
                if (clr_seen) begin
                    m_sticky = e[7:0];
                    m_err    = e[8] ? 8'd1 : 8'd0;
                end else begin
                    m_sticky = m_sticky | e[7:0];
                    if (e[8] && m_err != 8'hFF) m_err = m_err + 8'd1;
                end
            end
            chk("invariant", {31'd0, forbidden(status)}, 32'd0);
        end else if (clr_seen) begin
            m_sticky = 8'h00;
            m_err    = 8'h00;
        end
        if (out_valid) run++;
        else begin
            if (run > 0) last_run = run;
            run = 0;
        end
        chk("sticky_status", {24'd0, sticky_status}, {24'd0, m_sticky});
        chk("err_cnt", {24'd0, err_cnt}, {24'd0, m_err});
    end

    task automatic send(input logic [31:0] zz, input logic inx, input logic ovf, input logic unf,
                        input logic nn, input logic [7:0] es, input logic ei);
        in_valid = 1'b1; z = zz;
        inexact_in = inx; overflow_in = ovf; underflow_in = unf; nan_in = nn;
        exp_q.push_back({ei, es});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; z = 32'd0; sticky_clr = 1'b0;
        inexact_in = 1'b0; overflow_in = 1'b0; underflow_in = 1'b0; nan_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_status", {24'd0, status}, 32'd0);
        chk("reset_sticky", {24'd0, sticky_status}, 32'd0);
        chk("reset_err", {24'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;

        // Normal value and infinity with overflow
        send(32'h3F800000, 0, 0, 0, 0, 8'h00, 1'b0);
        idle(2);
        chk("one_err", {24'd0, err_cnt}, 32'd0);
        send(32'h7F800000, 1, 1, 0, 0, 8'h32, 1'b0);
        idle(3);
        chk("inf_err", {24'd0, err_cnt}, 32'd0);

        // Clear alone, then zero+tiny followed by a NaN
        sticky_clr = 1'b1; @(posedge clk); #1; sticky_clr = 1'b0;
        chk("clr_sticky", {24'd0, sticky_status}, 32'd0);
        send(32'h00000000, 1, 0, 1, 0, 8'h29, 1'b0);
        send(32'h7FC00000, 1, 0, 0, 0, 8'h04, 1'b1);
        idle(3);
        chk("seq_sticky", {24'd0, sticky_status}, 32'h2D);
        chk("seq_err", {24'd0, err_cnt}, 32'd1);

        // 300 back-to-back zero with overflow: saturation and unbroken out_valid
        for (int i = 0; i < 300; i++) send(32'h00000000, 0, 1, 0, 0, 8'h30, 1'b1);
        idle(4);
        chk("sat_run", last_run, 32'd300);
        chk("sat_err", {24'd0, err_cnt}, 32'hFF);

        // History to 3F, then clear coinciding with an emitted 02
        send(32'h7F800000, 0, 0, 0, 0, 8'h02, 1'b0);
        idle(3);
        chk("hist_sticky", {24'd0, sticky_status}, 32'h3F);
        send(32'h7F800000, 0, 0, 0, 0, 8'h02, 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        chk("clr_emit_valid", {31'd0, out_valid}, 32'd1);
        chk("clr_emit_sticky", {24'd0, sticky_status}, 32'h02);
        chk("clr_emit_err", {24'd0, err_cnt}, 32'd0);
        idle(2);
        sticky_clr = 1'b1; @(posedge clk); #1; sticky_clr = 1'b0;
        chk("clr2_sticky", {24'd0, sticky_status}, 32'd0);
        chk("clr2_err", {24'd0, err_cnt}, 32'd0);

        // Reset with two results in flight
        idle(2);
        send(32'h3F800000, 0, 0, 0, 0, 8'h00, 1'b0);
        send(32'h7F800000, 0, 0, 0, 0, 8'h02, 1'b0);
        send(32'h00000000, 0, 0, 0, 0, 8'h01, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_status", {24'd0, status}, 32'd0);
        chk("rst_sticky", {24'd0, sticky_status}, 32'd0);
        chk("rst_err", {24'd0, err_cnt}, 32'd0);
        idle(4);

        // Random sweep over interesting encodings
        for (int i = 0; i < 400; i++) begin
            logic [31:0] zs[9];
            logic [31:0] zz;
            logic inx, ovf, unf, nn;
            logic [8:0] r;
            zs = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'h7F800000, 32'hFF800000,
                   32'h7FC00000, 32'h7F800001, 32'h00400000, 32'h7F7FFFFF};
            zz  = zs[$urandom_range(0, 8)];
            inx = 1'($urandom_range(0, 1));
            ovf = 1'($urandom_range(0, 1));
            unf = 1'($urandom_range(0, 1));
            nn  = 1'($urandom_range(0, 1));
            sticky_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                r = ref_fn(zz, inx, ovf, unf, nn);
                send(zz, inx, ovf, unf, nn, r[7:0], r[8]);
            end
        end
        sticky_clr = 1'b0;
        idle(1);

        begin
            int guard = 0;
            while (exp_q.size() != 0 && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            chk("drain_queue", exp_q.size(), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_mult_status_gen.md
# fp_mult_status_gen

Pipelined generator for the 8-bit status byte of the floating-point multiplier, placed after the rounding stage. It turns the rounded single-precision result and the raw exception indications into one status byte per valid result. Priority rules guarantee the flag combinations the status checker forbids are never emitted. It also keeps a sticky cumulative status register and a saturating counter of inconsistent raw inputs.

## Interface
- No parameters; widths fixed (binary32 result, 8-bit status).
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  qualifies z and the raw flags this cycle.
- z  in  32  rounded result {sign, exp[7:0], mant[22:0]}.
- inexact_in  in  1  guard/round/sticky bits nonzero.
- overflow_in  in  1  exponent exceeded max normal before saturation.
- underflow_in  in  1  exponent below min normal before rounding.
- nan_in  in  1  invalid operation or NaN operand.
- sticky_clr  in  1  clears sticky_status and err_cnt.
- out_valid  out  1  status valid this cycle (single-cycle pulse per result).
- status  out  8  {0, 0, inexact_f, huge_f, tiny_f, nan_f, inf_f, zero_f}, bits 7..0.
- sticky_status  out  8  OR of all emitted status bytes since the last clear; bits 7:6 always 0.
- err_cnt  out  8  saturating count of inconsistent inputs.

## Operation
- Stage 1 registers z fields and the raw flags, plus these classifications:
  - exp_ones = (z[30:23]==8'hFF)
  - mant_zero = (z[22:0]==0)
  - mag_zero = (z[30:0]==0)
- Stage 2 applies the flag priority (NaN > huge > inf/zero > tiny):
  - nan_f = nan_in | (exp_ones & ~mant_zero).
  - huge_f = overflow_in & ~nan_f.
  - inf_f = exp_ones & mant_zero & ~nan_f.
  - zero_f = mag_zero & ~nan_f & ~huge_f.
  - tiny_f = underflow_in & ~nan_f & ~huge_f & ~inf_f.
  - inexact_f = (inexact_in | huge_f) & ~nan_f.
  - Bits 7:6 are always 0.
- The raw inputs are inconsistent (incons) if any of these holds:
  - overflow_in & underflow_in
  - nan_f & (overflow_in | underflow_in | inexact_in)
  - overflow_in & mag_zero
  - underflow_in & exp_ones
- On each stage-2 valid with incons, err_cnt increments and saturates at 8'hFF.
- Sticky register:
  - On out_valid: sticky_status <= sticky_status | status.
  - On sticky_clr without out_valid: sticky_status <= 0 and err_cnt <= 0.
  - On sticky_clr with out_valid in the same cycle: sticky_status <= status and err_cnt <= incons ? 1 : 0. The clear removes old history; the new result is kept.
- No backpressure. One result can be accepted every cycle.
- Invariant: status never contains any of the pairs zero&inf, zero&nan, zero&huge, inf&tiny, nan&tiny, nan&huge, nan&inexact, huge&tiny.

## Timing
- Latency 2: in_valid sampled at edge k gives out_valid=1 and status after edge k+2.
- sticky_status and err_cnt update on the same edge k+2.
- Full throughput. Back-to-back in_valid gives back-to-back out_valid with results in order.
- status holds its last value when out_valid=0. It is only meaningful while out_valid=1.
- Reset (rst_n=0 at an edge) clears both pipeline valid bits, status, out_valid, sticky_status and err_cnt to 0.
- Results in flight when reset is applied are dropped; no out_valid is produced for them.
- in_valid=0 cycles leave bubbles in the pipeline. They do not change sticky_status or err_cnt.

## Test plan
- z=32'h3F800000, all raw flags 0 -> after 2 cycles status=8'h00, err_cnt=0.
- z=32'h7F800000, overflow_in=1, inexact_in=1 -> status=8'h32 (inexact, huge, inf), err_cnt unchanged.
- z=32'h00000000, underflow_in=1, inexact_in=1 -> status=8'h29 (inexact, tiny, zero). Then z=32'h7FC00000, inexact_in=1 -> status=8'h04, err_cnt=1, sticky_status=8'h2D.
- z=32'h00000000, overflow_in=1 -> status=8'h30 (zero suppressed), err_cnt increments. Drive 300 such inputs back-to-back: out_valid is high for 300 consecutive cycles and err_cnt saturates at 8'hFF.
- sticky_clr asserted in the same cycle out_valid carries 8'h02 (after history 8'h3F) -> sticky_status=8'h02. sticky_clr alone -> sticky_status=8'h00, err_cnt=0.
- Three back-to-back in_valid, then rst_n=0 for one cycle while two are in flight -> no out_valid is produced for the in-flight results, and all outputs read 0 after the reset edge.
- Random stimulus over all scenarios: every emitted status passes the forbidden-pair invariant.
